// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART host controller: FSM state
// encoding, status word bit positions and the default UART register map.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POLL      = 3'd1,
    ST_POLL_WAIT = 3'd2,
    ST_RX_READ   = 3'd3,
    ST_RX_WAIT   = 3'd4,
    ST_TX_WRITE  = 3'd5
  } ctrl_state_e;

  localparam int STATUS_RX_BIT = 0;
  localparam int STATUS_TX_BIT = 1;

  localparam int DEFAULT_RX_ADDRESS     = 0;
  localparam int DEFAULT_TX_ADDRESS     = 1;
  localparam int DEFAULT_STATUS_ADDRESS = 2;

endpackage

// File: rtl/uart_host_ctrl_if.sv
// UART register bus between the host controller (master) and the UART core (slave).
interface uart_host_ctrl_if #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic                     uart_read_enable;
  logic                     uart_write_enable;
  logic [ADDRESS_WIDTH-1:0] uart_active_address;
  logic [WIDTH-1:0]         uart_data_in;
  logic [WIDTH-1:0]         uart_data_out;

  modport master (
    output uart_read_enable, uart_write_enable, uart_active_address, uart_data_in,
    input  uart_data_out
  );

  modport slave (
    input  uart_read_enable, uart_write_enable, uart_active_address, uart_data_in,
    output uart_data_out
  );
endinterface

// File: rtl/uart_host_ctrl_rr_arbiter.sv
// Two-requester round-robin arbiter; the registered grant doubles as the
// last-grant memory that breaks the next tie.
module uart_rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_q
);
  logic next_grant;

  // On a tie the requester not granted last wins; a lone requester wins outright.
  always_comb next_grant = (req == 2'b11) ? ~grant_q : req[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       grant_q <= 1'b1;
    else if (update) grant_q <= next_grant;
  end
endmodule

// File: rtl/uart_host_ctrl.sv
// Polling UART host: reads the status register continuously and moves bytes
// between the UART and one rx stream plus two arbitrated tx streams.
module uart_host_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int RX_ADDRESS     = DEFAULT_RX_ADDRESS,
  parameter int TX_ADDRESS     = DEFAULT_TX_ADDRESS,
  parameter int STATUS_ADDRESS = DEFAULT_STATUS_ADDRESS
) (
  input  logic              clock,
  input  logic              reset,
  uart_host_ctrl_if.master  uart,
  input  logic              tx0_valid,
  input  logic [WIDTH-1:0]  tx0_data,
  output logic              tx0_ready,
  input  logic              tx1_valid,
  input  logic [WIDTH-1:0]  tx1_data,
  output logic              tx1_ready,
  output logic              rx_valid,
  output logic [WIDTH-1:0]  rx_data,
  input  logic              rx_ready,
  output logic              busy
);
  // state      | meaning
  // IDLE       | one-cycle gap between polls
  // POLL       | status read strobe
  // POLL_WAIT  | status on uart_data_out, pick rx / tx / nothing
  // RX_READ    | rx data read strobe
  // RX_WAIT    | rx byte on uart_data_out, capture into holding register
  // TX_WRITE   | tx write strobe with granted byte, granted ready pulse
  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_POLL      = ST_POLL;
  localparam logic [2:0] S_POLL_WAIT = ST_POLL_WAIT;
  localparam logic [2:0] S_RX_READ   = ST_RX_READ;
  localparam logic [2:0] S_RX_WAIT   = ST_RX_WAIT;
  localparam logic [2:0] S_TX_WRITE  = ST_TX_WRITE;

  logic [2:0] state, next_state;
  logic       svc_tx_q;
  logic       rx_cand, tx_cand, pick_rx, pick_tx;
  logic       grant_q;

  always_comb begin
    rx_cand = uart.uart_data_out[STATUS_RX_BIT] && !rx_valid;
    tx_cand = uart.uart_data_out[STATUS_TX_BIT] && (tx0_valid || tx1_valid);
    pick_rx = rx_cand && (!tx_cand || !svc_tx_q);
    pick_tx = tx_cand && !pick_rx;
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:      next_state = S_POLL;
      S_POLL:      next_state = S_POLL_WAIT;
      S_POLL_WAIT: next_state = pick_rx ? S_RX_READ : (pick_tx ? S_TX_WRITE : S_IDLE);
      S_RX_READ:   next_state = S_RX_WAIT;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // The service flag only moves when rx and tx actually contend.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                            svc_tx_q <= 1'b0;
    else if (state == S_POLL_WAIT && rx_cand && tx_cand)  svc_tx_q <= ~svc_tx_q;
  end

  uart_rr_arbiter u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({tx1_valid, tx0_valid}),
    .update  (state == S_POLL_WAIT && pick_tx),
    .grant_q (grant_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (state == S_RX_WAIT) begin
      rx_valid <= 1'b1;
      rx_data  <= uart.uart_data_out;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Bus outputs decode straight from state so reset clears them immediately.
  always_comb begin
    uart.uart_read_enable    = 1'b0;
    uart.uart_write_enable   = 1'b0;
    uart.uart_active_address = '0;
    uart.uart_data_in        = '0;
    tx0_ready                = 1'b0;
    tx1_ready                = 1'b0;
    case (state)
      S_POLL: begin
        uart.uart_read_enable    = 1'b1;
        uart.uart_active_address = ADDRESS_WIDTH'(STATUS_ADDRESS);
      end
      S_RX_READ: begin
        uart.uart_read_enable    = 1'b1;
        uart.uart_active_address = ADDRESS_WIDTH'(RX_ADDRESS);
      end
      S_TX_WRITE: begin
        uart.uart_write_enable   = 1'b1;
        uart.uart_active_address = ADDRESS_WIDTH'(TX_ADDRESS);
        uart.uart_data_in        = grant_q ? tx1_data : tx0_data;
        tx0_ready                = ~grant_q;
        tx1_ready                = grant_q;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed bench for uart_host_ctrl: a behavioural UART register model and
// two tx requester queues around the DUT, with hand-computed expectations.
module tb_uart_host_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx0_valid = 1'b0, tx1_valid = 1'b0, rx_ready = 1'b0;
  logic [7:0] tx0_data = '0, tx1_data = '0;
  logic       tx0_ready, tx1_ready, rx_valid, busy;
  logic [7:0] rx_data;

  uart_host_ctrl_if #(.WIDTH(8), .ADDRESS_WIDTH(4)) ubus ();

  uart_host_ctrl dut (
    .clock(clock), .reset(reset), .uart(ubus),
    .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
    .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0, viol = 0, n_rx_reads = 0;
  logic [7:0] status = '0, rx_byte = '0;
  logic [7:0] q0[$], q1[$], wr_data[$], ev[$];
  logic [3:0] wr_addr[$];
  logic [1:0] wr_rdy[$];
  logic       prev_rd = 1'b0, prev_wr = 1'b0, prev_busy = 1'b1, saw_rx_read = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_tx();
    tx0_valid = (q0.size() > 0);
    tx0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
    tx1_valid = (q1.size() > 0);
    tx1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  // One clock: observe at the falling edge, update models just after the rising edge.
  task automatic tick();
    logic rd, wr, pop0, pop1;
    logic [3:0] addr;
    @(negedge clock);
    rd   = ubus.uart_read_enable;
    wr   = ubus.uart_write_enable;
    addr = ubus.uart_active_address;
    if (rd && wr) viol++;
    if ((rd && prev_rd) || (wr && prev_wr)) viol++;
    if (!rd && !wr && (addr != 4'd0 || ubus.uart_data_in != 8'd0)) viol++;
    if ((rd || wr) && !busy) viol++;
    if (!wr && (tx0_ready || tx1_ready)) viol++;
    if (!reset && !busy && !prev_busy) viol++;
    saw_rx_read = rd && addr == 4'd0;
    if (saw_rx_read) begin n_rx_reads++; ev.push_back(8'h52); end
    if (wr) begin
      wr_addr.push_back(addr);
      wr_data.push_back(ubus.uart_data_in);
      wr_rdy.push_back({tx1_ready, tx0_ready});
      ev.push_back(8'h54);
    end
    pop0 = tx0_ready && tx0_valid;
    pop1 = tx1_ready && tx1_valid;
    prev_rd = rd; prev_wr = wr; prev_busy = busy;
    @(posedge clock);
    #1;
    if (rd) ubus.uart_data_out = (addr == 4'd2) ? status : (addr == 4'd0) ? rx_byte : 8'h00;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    drive_tx();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete(); q1.delete(); drive_tx();
    rx_ready = 1'b0; status = 8'h00; rx_byte = 8'h00;
    ubus.uart_data_out = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_outputs",
             {ubus.uart_read_enable, ubus.uart_write_enable, ubus.uart_active_address,
              ubus.uart_data_in, tx0_ready, tx1_ready, rx_valid, rx_data, busy}, 0);
    reset = 1'b0;
    wr_addr.delete(); wr_data.delete(); wr_rdy.delete(); ev.delete();
    n_rx_reads = 0; prev_rd = 1'b0; prev_wr = 1'b0; prev_busy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_alt[6];
    logic [7:0] exp_ev[6];
    logic       reached;
    exp_alt = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};
    exp_ev  = '{8'h52, 8'h54, 8'h52, 8'h54, 8'h52, 8'h54};

    // single tx0 write
    do_reset();
    status = 8'h02;
    q0.push_back(8'hA5); drive_tx();
    repeat (20) tick();
    check_eq("tx0_write_count", wr_data.size(), 1);
    if (wr_data.size() > 0) begin
      check_eq("tx0_write_addr", wr_addr[0], 1);
      check_eq("tx0_write_data", wr_data[0], 8'hA5);
      check_eq("tx0_ready_pulse", wr_rdy[0], 2'b01);
    end

    // both requesters held valid: alternate starting with tx0
    do_reset();
    status = 8'h02;
    repeat (3) begin q0.push_back(8'h11); q1.push_back(8'h22); end
    drive_tx();
    repeat (40) tick();
    check_eq("alt_write_count", wr_data.size(), 6);
    for (int i = 0; i < 6 && i < wr_data.size(); i++) begin
      check_eq($sformatf("alt_data_%0d", i), wr_data[i], exp_alt[i]);
      check_eq($sformatf("alt_ready_%0d", i), wr_rdy[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // rx byte held until consumer accepts
    do_reset();
    status = 8'h01; rx_byte = 8'h5C;
    repeat (30) tick();
    check_eq("rx_valid_held", rx_valid, 1);
    check_eq("rx_data_held", rx_data, 8'h5C);
    check_eq("rx_single_read", n_rx_reads, 1);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    check_eq("rx_valid_cleared", rx_valid, 0);
    rx_byte = 8'h3A;
    repeat (20) tick();
    check_eq("rx_second_read", n_rx_reads, 2);
    check_eq("rx_second_data", rx_data, 8'h3A);
    check_eq("rx_second_valid", rx_valid, 1);

    // rx_ready without rx_valid does nothing
    do_reset();
    rx_ready = 1'b1;
    repeat (10) tick();
    check_eq("rx_ready_idle", {rx_valid, rx_data}, 0);
    rx_ready = 1'b0;

    // rx and tx contending: rx first, then alternate
    do_reset();
    status = 8'h03; rx_byte = 8'h77; rx_ready = 1'b1;
    q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h43); drive_tx();
    repeat (40) tick();
    check_eq("mix_event_count_ge6", ev.size() >= 6, 1);
    for (int i = 0; i < 6 && i < ev.size(); i++)
      check_eq($sformatf("mix_event_%0d", i), ev[i], exp_ev[i]);
    check_eq("mix_tx_count", wr_data.size(), 3);
    if (wr_data.size() == 3) check_eq("mix_tx_last", wr_data[2], 8'h43);
    rx_ready = 1'b0;

    // reset during RX_WAIT drops the byte
    do_reset();
    status = 8'h01; rx_byte = 8'h99;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      tick();
      reached = saw_rx_read;
    end
    check_eq("rx_wait_reached", reached, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_reset_outputs",
             {ubus.uart_read_enable, ubus.uart_write_enable, ubus.uart_active_address,
              ubus.uart_data_in, tx0_ready, tx1_ready, rx_valid, rx_data, busy}, 0);
    @(posedge clock);
    #1;
    status = 8'h00; ubus.uart_data_out = 8'h00;
    reset = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_busy = 1'b1;
    repeat (10) tick();
    check_eq("rx_dropped_after_reset", {rx_valid, rx_data}, 0);

    check_eq("protocol_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
